// File: rtl/bridge_rshift_seq_pkg.sv
// Shared types and limits for the bridge/right-shift read sequencer.
// Optional perf counters in the top are enabled by BRIDGE_SEQ_PERF_EN.
package self_attention_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        SHIFT,
        DONE
    } bridge_seq_state_t;

    localparam int BRIDGE_SEQ_MAX_RD_LAT = 4;

endpackage

// File: rtl/bridge_rshift_seq_rd_valid_pipe.sv
// Delay line carrying {rd_enb, rd_ena} across the BRAM read latency.
// empty is high once no beat remains behind the output stage.
module rd_valid_pipe
    import self_attention_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] en,
    output logic [1:0] en_dly,
    output logic       empty
);

    logic [1:0] stage [DEPTH];
    logic       pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else begin
            stage[0] <= en;
            for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
    end

    // the output stage is excluded: its beat is already presented
    always_comb begin
        pending = |en;
        for (int k = 0; k < DEPTH - 1; k++) pending = pending | (|stage[k]);
    end

    assign en_dly = stage[DEPTH-1];
    assign empty  = ~pending;

endmodule

// File: rtl/bridge_rshift_seq.sv
// Read-side sequencer: dual-port BRAM read, drain, right-shift, done.
// Define BRIDGE_SEQ_PERF_EN to add the perf_cycles/perf_stalls counters.
module bridge_rshift_seq
    import self_attention_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_ELEMENTS = 64,
    parameter int SHIFT_STEPS  = 16,
    parameter int RD_LATENCY   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_start,
    input  logic                             out_ready,
    output logic                             rd_ena,
    output logic [ADDR_WIDTH-1:0]            rd_addra,
    output logic                             rd_enb,
    output logic [ADDR_WIDTH-1:0]            rd_addrb,
    output logic                             data_valid_a,
    output logic                             data_valid_b,
    output logic                             shift_en,
    output logic [$clog2(SHIFT_STEPS+1)-1:0] shift_cnt,
    output logic                             busy,
`ifdef BRIDGE_SEQ_PERF_EN
    output logic [31:0]                      perf_cycles,
    output logic [31:0]                      perf_stalls,
`endif
    output logic                             done
);

    localparam int NUM_PAIRS = (NUM_ELEMENTS + 1) / 2;
    localparam int PAIR_W    = $clog2(NUM_PAIRS + 1);
    localparam int CNT_W     = $clog2(SHIFT_STEPS + 1);

    generate
        if (NUM_ELEMENTS > 2 ** ADDR_WIDTH) begin : g_bad_addr
            $error("NUM_ELEMENTS exceeds the BRAM address range");
        end
        if (RD_LATENCY < 1 || RD_LATENCY > BRIDGE_SEQ_MAX_RD_LAT) begin : g_bad_lat
            $error("RD_LATENCY out of range");
        end
    endgenerate

    bridge_seq_state_t state, state_nxt;

    logic [PAIR_W-1:0]     pair, pair_nxt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [ADDR_WIDTH-1:0] addra_nxt, addrb_nxt;
    logic                  ena_nxt, enb_nxt;
    logic                  shift_nxt, busy_nxt, done_nxt;
    logic [31:0]           even_addr;
    logic                  pipe_empty;

    rd_valid_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_valid_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     ({rd_enb, rd_ena}),
        .en_dly ({data_valid_b, data_valid_a}),
        .empty  (pipe_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pair      <= '0;
            shift_cnt <= '0;
            rd_ena    <= 1'b0;
            rd_enb    <= 1'b0;
            rd_addra  <= '0;
            rd_addrb  <= '0;
            shift_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pair      <= pair_nxt;
            shift_cnt <= cnt_nxt;
            rd_ena    <= ena_nxt;
            rd_enb    <= enb_nxt;
            rd_addra  <= addra_nxt;
            rd_addrb  <= addrb_nxt;
            shift_en  <= shift_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pair_nxt  = pair;
        cnt_nxt   = shift_cnt;
        ena_nxt   = 1'b0;
        enb_nxt   = 1'b0;
        addra_nxt = '0;
        addrb_nxt = '0;
        shift_nxt = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        even_addr = 32'(pair) << 1;
        unique case (state)
            IDLE: begin
                if (in_start) begin
                    state_nxt = READ;
                    busy_nxt  = 1'b1;
                    pair_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            READ: begin
                if (out_ready) begin
                    ena_nxt   = 1'b1;
                    addra_nxt = ADDR_WIDTH'(even_addr);
                    // an odd element count leaves port B idle on the last pair
                    if (even_addr + 32'd1 < 32'(NUM_ELEMENTS)) begin
                        enb_nxt   = 1'b1;
                        addrb_nxt = ADDR_WIDTH'(even_addr + 32'd1);
                    end
                    pair_nxt = pair + 1'b1;
                    if (pair == PAIR_W'(NUM_PAIRS - 1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_nxt = SHIFT;
                    shift_nxt = 1'b1;
                end
            end
            SHIFT: begin
                cnt_nxt = shift_cnt + 1'b1;
                if (cnt_nxt == CNT_W'(SHIFT_STEPS)) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    shift_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

`ifdef BRIDGE_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state == IDLE && in_start) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy && perf_cycles != '1)
                perf_cycles <= perf_cycles + 32'd1;
            if (state == READ && !out_ready && perf_stalls != '1)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bridge_rshift_seq.sv
// Scoreboard bench: stimulus queues expected addresses and done timing,
// per-instance monitors pop and compare as the sequencer produces them.
module tb_bridge_rshift_seq;

    localparam int AW = 8;
    localparam int N0 = 64;
    localparam int S0 = 16;
    localparam int L0 = 2;
    localparam int N1 = 7;
    localparam int S1 = 4;
    localparam int L1 = 3;
    localparam int C0W = $clog2(S0 + 1);
    localparam int C1W = $clog2(S1 + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start0 = 1'b0, ready0 = 1'b1;
    logic start1 = 1'b0, ready1 = 1'b1;
    logic ena0, enb0, va0, vb0, sh0, busy0, done0;
    logic ena1, enb1, va1, vb1, sh1, busy1, done1;
    logic [AW-1:0] aa0, ab0, aa1, ab1;
    logic [C0W-1:0] cnt0;
    logic [C1W-1:0] cnt1;
`ifdef BRIDGE_SEQ_PERF_EN
    logic [31:0] pc0, ps0, pc1, ps1;
`endif

    bridge_rshift_seq #(
        .ADDR_WIDTH(AW), .NUM_ELEMENTS(N0),
        .SHIFT_STEPS(S0), .RD_LATENCY(L0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .in_start(start0), .out_ready(ready0),
        .rd_ena(ena0), .rd_addra(aa0), .rd_enb(enb0), .rd_addrb(ab0),
        .data_valid_a(va0), .data_valid_b(vb0), .shift_en(sh0),
        .shift_cnt(cnt0), .busy(busy0),
`ifdef BRIDGE_SEQ_PERF_EN
        .perf_cycles(pc0), .perf_stalls(ps0),
`endif
        .done(done0)
    );

    bridge_rshift_seq #(
        .ADDR_WIDTH(AW), .NUM_ELEMENTS(N1),
        .SHIFT_STEPS(S1), .RD_LATENCY(L1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .in_start(start1), .out_ready(ready1),
        .rd_ena(ena1), .rd_addra(aa1), .rd_enb(enb1), .rd_addrb(ab1),
        .data_valid_a(va1), .data_valid_b(vb1), .shift_en(sh1),
        .shift_cnt(cnt1), .busy(busy1),
`ifdef BRIDGE_SEQ_PERF_EN
        .perf_cycles(pc1), .perf_stalls(ps1),
`endif
        .done(done1)
    );

    int total = 0;
    int bad = 0;
    int qa0[$], qb0[$], qd0[$];
    int qa1[$], qb1[$], qd1[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push0(input int stall, input bit with_done);
        for (int a = 0; a < N0; a++) begin
            if (a % 2 == 0) qa0.push_back(a);
            else qb0.push_back(a);
        end
        if (with_done) qd0.push_back(N0 / 2 + L0 + S0 + 1 + stall);
    endtask

    task automatic wait_done0(input int budget);
        int n = 0;
        while (!done0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done0) chk("done0 timeout", 32'd0, 32'd1);
    endtask

    // monitor for the 64-element instance
    initial begin : mon0
        logic [1:0] h[L0];
        logic [1:0] ev;
        logic pb;
        int k, shn;
        pb = 1'b0; k = 0; shn = 0;
        for (int i = 0; i < L0; i++) h[i] = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int i = 0; i < L0; i++) h[i] = 2'b00;
                pb = 1'b0;
                continue;
            end
            if (busy0 && !pb) begin
                k = 0;
                shn = 0;
            end else begin
                k++;
            end
            pb = busy0;
            ev = h[L0-1];
            if (ev != 2'b00 || va0 || vb0)
                chk("valid0", 32'({vb0, va0}), 32'(ev));
            for (int i = L0 - 1; i > 0; i--) h[i] = h[i-1];
            h[0] = {enb0, ena0};
            if (ena0) begin
                if (qa0.size() == 0) chk("addra0 extra", 32'(aa0), 32'hffff);
                else chk("addra0", 32'(aa0), 32'(qa0.pop_front()));
            end
            if (enb0) begin
                if (qb0.size() == 0) chk("addrb0 extra", 32'(ab0), 32'hffff);
                else chk("addrb0", 32'(ab0), 32'(qb0.pop_front()));
            end
            if (sh0) shn++;
            if (done0) begin
                if (qd0.size() == 0) begin
                    chk("done0 unexpected", 32'd1, 32'd0);
                end else begin
                    chk("done0 cycle", 32'(k), 32'(qd0.pop_front()));
                    chk("shift pulses0", 32'(shn), 32'(S0));
                    chk("shift_cnt0 at done", 32'(cnt0), 32'(S0));
                end
            end
        end
    end

    // monitor for the 7-element instance
    initial begin : mon1
        logic [1:0] h[L1];
        logic [1:0] ev;
        logic pb;
        int k, beats;
        pb = 1'b0; k = 0; beats = 0;
        for (int i = 0; i < L1; i++) h[i] = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int i = 0; i < L1; i++) h[i] = 2'b00;
                pb = 1'b0;
                continue;
            end
            if (busy1 && !pb) begin
                k = 0;
                beats = 0;
            end else begin
                k++;
            end
            pb = busy1;
            ev = h[L1-1];
            if (ev != 2'b00 || va1 || vb1)
                chk("valid1", 32'({vb1, va1}), 32'(ev));
            for (int i = L1 - 1; i > 0; i--) h[i] = h[i-1];
            h[0] = {enb1, ena1};
            beats += int'(va1) + int'(vb1);
            if (ena1) begin
                if (qa1.size() == 0) chk("addra1 extra", 32'(aa1), 32'hffff);
                else chk("addra1", 32'(aa1), 32'(qa1.pop_front()));
                if (aa1 == AW'(N1 - 1))
                    chk("last pair port B idle", 32'({enb1, ab1}), 32'd0);
            end
            if (enb1) begin
                if (qb1.size() == 0) chk("addrb1 extra", 32'(ab1), 32'hffff);
                else chk("addrb1", 32'(ab1), 32'(qb1.pop_front()));
            end
            if (done1) begin
                if (qd1.size() == 0) begin
                    chk("done1 unexpected", 32'd1, 32'd0);
                end else begin
                    chk("done1 cycle", 32'(k), 32'(qd1.pop_front()));
                    chk("valid beats1", 32'(beats), 32'(N1));
                end
            end
        end
    end

    initial begin : stim
        int n;
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset rd_ena", 32'(ena0), 32'd0);
        chk("reset rd_enb", 32'(enb0), 32'd0);
        chk("reset addrs", 32'({aa0, ab0}), 32'd0);
        chk("reset valids", 32'({va0, vb0}), 32'd0);
        chk("reset shift", 32'({sh0, cnt0}), 32'd0);
        chk("reset busy/done", 32'({busy0, done0}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // full pass, out_ready held high
        push0(0, 1'b1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("busy after start", 32'(busy0), 32'd1);
        @(negedge clk);
        chk("first issue", 32'({ena0, enb0}), 32'd3);
        chk("first addra", 32'(aa0), 32'd0);
        chk("first addrb", 32'(ab0), 32'd1);
        wait_done0(200);

        // start in DONE is ignored; start one cycle later begins a stalled pass
        push0(5, 1'b1);
        start0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        ready0 = 1'b0;
        repeat (5) @(negedge clk);
        ready0 = 1'b1;
        wait_done0(200);
        repeat (2) @(negedge clk);
        chk("idle after stalled pass", 32'(busy0), 32'd0);
`ifdef BRIDGE_SEQ_PERF_EN
        chk("perf_stalls", ps0, 32'd5);
        chk("perf_cycles", pc0, 32'd57);
`endif

        // spurious starts during READ and DONE
        push0(0, 1'b1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (10) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(200);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("DONE-cycle start ignored", 32'(busy0), 32'd0);

        // reset pulse in the middle of SHIFT
        push0(0, 1'b0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!sh0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reached SHIFT", 32'(sh0), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid-shift reset busy", 32'(busy0), 32'd0);
        chk("mid-shift reset shift_en", 32'(sh0), 32'd0);
        chk("mid-shift reset shift_cnt", 32'(cnt0), 32'd0);
        chk("mid-shift reset done", 32'(done0), 32'd0);
        repeat (30) @(negedge clk);

        // odd element count on the second instance
        for (int a = 0; a < N1; a++) begin
            if (a % 2 == 0) qa1.push_back(a);
            else qb1.push_back(a);
        end
        qd1.push_back((N1 + 1) / 2 + L1 + S1 + 1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done1) chk("done1 timeout", 32'd0, 32'd1);
        repeat (5) @(negedge clk);

        chk("leftover addra0", 32'(qa0.size()), 32'd0);
        chk("leftover addrb0", 32'(qb0.size()), 32'd0);
        chk("missing done0", 32'(qd0.size()), 32'd0);
        chk("leftover addr1", 32'(qa1.size() + qb1.size()), 32'd0);
        chk("missing done1", 32'(qd1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
